// File: rtl/radix2_div_if.sv
// radix2_div_if: request/result handshake bundle shared by the iterative
// divider and the execute stage. The producer side (master) raises a request
// and consumes results; the divider side (slave) reports busy/valid and
// presents the quotient, remainder and divide-by-zero flag.
interface radix2_div_if #(
  parameter int WIDTH = 64
) ();

  logic             div_datavaild_i;
  logic             div_signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             div_ready;
  logic             div_doing_o;
  logic             div_valid_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_by_zero_o;

  modport master (
    output div_datavaild_i,
    output div_signed_i,
    output dividend_i,
    output divisor_i,
    output div_ready,
    input  div_doing_o,
    input  div_valid_o,
    input  quotient_o,
    input  remainder_o,
    input  div_by_zero_o
  );

  modport slave (
    input  div_datavaild_i,
    input  div_signed_i,
    input  dividend_i,
    input  divisor_i,
    input  div_ready,
    output div_doing_o,
    output div_valid_o,
    output quotient_o,
    output remainder_o,
    output div_by_zero_o
  );

endinterface

// File: rtl/radix2_div.sv
// radix2_div: iterative restoring radix-2 integer divider, one quotient bit
// per cycle. Results are held in DONE until the consumer raises div_ready and
// stay on quotient_o/remainder_o until the next result overwrites them.
// Divide-by-zero bypasses the iteration and returns all ones / the dividend.
// Optional feature macro: RADIX2_DIV_SIGNED_EN compiles in two's-complement
// division (operand magnitudes, sign latching and result sign fix-up). When it
// is undefined div_signed_i is ignored and every request is unsigned.
module radix2_div #(
  parameter int WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst,
  radix2_div_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quotient_fix;
  logic [WIDTH-1:0] remainder_fix;

`ifdef RADIX2_DIV_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
  logic req_dvd_neg;
  logic req_dvs_neg;

  // Operand magnitudes for a signed request and sign-corrected final results.
  always_comb begin
    req_dvd_neg   = bus.div_signed_i & bus.dividend_i[WIDTH-1];
    req_dvs_neg   = bus.div_signed_i & bus.divisor_i[WIDTH-1];
    dividend_mag  = req_dvd_neg ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
    divisor_mag   = req_dvs_neg ? (~bus.divisor_i + 1'b1) : bus.divisor_i;
    quotient_fix  = (dvd_neg ^ dvs_neg) ? (~dvd + 1'b1) : dvd;
    remainder_fix = dvd_neg ? (~rem + 1'b1) : rem;
  end
`else
  // Unsigned only: operands and raw results pass straight through.
  always_comb begin
    dividend_mag  = bus.dividend_i;
    divisor_mag   = bus.divisor_i;
    quotient_fix  = dvd;
    remainder_fix = rem;
  end
`endif

  // One restoring step: shift {rem, dvd} left and trial-subtract the divisor.
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], q_bit};
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      rem               <= '0;
      dvd               <= '0;
      dvs               <= '0;
`ifdef RADIX2_DIV_SIGNED_EN
      dvd_neg           <= 1'b0;
      dvs_neg           <= 1'b0;
`endif
      bus.div_doing_o   <= 1'b0;
      bus.div_valid_o   <= 1'b0;
      bus.quotient_o    <= '0;
      bus.remainder_o   <= '0;
      bus.div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.div_datavaild_i) begin
            bus.div_doing_o <= 1'b1;
            if (bus.divisor_i == '0) begin
              bus.quotient_o    <= '1;
              bus.remainder_o   <= bus.dividend_i;
              bus.div_by_zero_o <= 1'b1;
              state             <= DONE;
            end else begin
              dvd   <= dividend_mag;
              dvs   <= divisor_mag;
              rem   <= '0;
              cnt   <= '0;
`ifdef RADIX2_DIV_SIGNED_EN
              dvd_neg <= req_dvd_neg;
              dvs_neg <= req_dvs_neg;
`endif
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt == CNT_W'(WIDTH)) begin
            bus.quotient_o    <= quotient_fix;
            bus.remainder_o   <= remainder_fix;
            bus.div_by_zero_o <= 1'b0;
            bus.div_valid_o   <= 1'b1;
            state             <= DONE;
          end else begin
            rem <= rem_next;
            dvd <= dvd_next;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!bus.div_valid_o) begin
            bus.div_valid_o <= 1'b1;
          end else if (bus.div_ready) begin
            bus.div_valid_o <= 1'b0;
            bus.div_doing_o <= 1'b0;
            state           <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radix2_div.sv
// tb_radix2_div: randomized self-checking bench for radix2_div. Expected
// results come from plain SystemVerilog division in a reference function;
// the signed expectation follows RADIX2_DIV_SIGNED_EN as seen by the bench.
module tb_radix2_div;

  localparam int          WIDTH   = 64;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam int          CALC_LAT = 65;
  localparam int          MAX_WAIT = 200;

`ifdef RADIX2_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  radix2_div_if #(.WIDTH(WIDTH)) bus ();

  radix2_div #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: quotient/remainder straight from SV arithmetic rules.
  function automatic void model_div(input logic [63:0] a, input logic [63:0] b,
                                    input bit s, output logic [63:0] q,
                                    output logic [63:0] r, output bit z);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    bit                 use_signed;
    use_signed = s && SIGNED_EN;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (b == 64'd0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (use_signed) begin
      if (a == MIN_NEG && b == '1) begin
        q = MIN_NEG;
        r = 64'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Present a request at a falling edge, let the next rising edge accept it,
  // and return at the falling edge after acceptance with the request dropped.
  task automatic drive_req(input logic [63:0] a, input logic [63:0] b, input bit s);
    @(negedge clk);
    bus.dividend_i      = a;
    bus.divisor_i       = b;
    bus.div_signed_i    = s;
    bus.div_datavaild_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.div_datavaild_i = 1'b0;
  endtask

  // Count falling edges after acceptance until valid appears (bounded).
  task automatic await_result(output int lat, output logic [63:0] q,
                              output logic [63:0] r, output bit z);
    lat = 0;
    while (bus.div_valid_o !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    q = bus.quotient_o;
    r = bus.remainder_o;
    z = bus.div_by_zero_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.div_doing_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_doing: got %b expected 0", bus.div_doing_o);
    end
    n_checks++;
    if (bus.div_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_valid: got %b expected 0", bus.div_valid_o);
    end
    n_checks++;
    if (bus.quotient_o !== 64'd0 || bus.remainder_o !== 64'd0 || bus.div_by_zero_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_results: got q=%h r=%h z=%b expected zeros",
               bus.quotient_o, bus.remainder_o, bus.div_by_zero_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int          lat;
    logic [63:0] q;
    logic [63:0] r;
    bit          z;
    bus.div_ready = 1'b1;
    drive_req(64'd100, 64'd7, 1'b0);
    await_result(lat, q, r, z);
    n_checks++;
    if (lat !== CALC_LAT) begin
      n_fail++;
      $display("[TB] FAIL unsigned_latency: got %0d expected %0d", lat, CALC_LAT);
    end
    n_checks++;
    if (q !== 64'd14 || r !== 64'd2 || z !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL unsigned_100_7: got q=%0d r=%0d z=%b expected q=14 r=2 z=0", q, r, z);
    end
    @(negedge clk);
    n_checks++;
    if (bus.div_valid_o !== 1'b0 || bus.div_doing_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL unsigned_pulse: got valid=%b doing=%b expected 0 0",
               bus.div_valid_o, bus.div_doing_o);
    end
    n_checks++;
    if (bus.quotient_o !== 64'd14 || bus.remainder_o !== 64'd2) begin
      n_fail++;
      $display("[TB] FAIL unsigned_hold: got q=%0d r=%0d expected q=14 r=2",
               bus.quotient_o, bus.remainder_o);
    end
  endtask

  task automatic test_signed();
    int          lat;
    logic [63:0] q;
    logic [63:0] r;
    bit          z;
    logic [63:0] eq;
    logic [63:0] er;
    bit          ez;
    logic [63:0] a_tab [2];
    logic [63:0] b_tab [2];
    a_tab[0] = 64'hFFFF_FFFF_FFFF_FFF9;
    b_tab[0] = 64'd2;
    a_tab[1] = MIN_NEG;
    b_tab[1] = '1;
    bus.div_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_div(a_tab[i], b_tab[i], 1'b1, eq, er, ez);
      drive_req(a_tab[i], b_tab[i], 1'b1);
      await_result(lat, q, r, z);
      n_checks++;
      if (lat !== CALC_LAT) begin
        n_fail++;
        $display("[TB] FAIL signed_latency[%0d]: got %0d expected %0d", i, lat, CALC_LAT);
      end
      n_checks++;
      if (q !== eq || r !== er || z !== ez) begin
        n_fail++;
        $display("[TB] FAIL signed_result[%0d]: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                 i, q, r, z, eq, er, ez);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int          lat;
    logic [63:0] q;
    logic [63:0] r;
    bit          z;
    bus.div_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      drive_req(64'd5, 64'd0, s[0]);
      await_result(lat, q, r, z);
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("[TB] FAIL divzero_latency[%0d]: got %0d expected 1", s, lat);
      end
      n_checks++;
      if (q !== '1 || r !== 64'd5 || z !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL divzero_result[%0d]: got q=%h r=%h z=%b expected q=ffffffffffffffff r=5 z=1",
                 s, q, r, z);
      end
      @(negedge clk);
      n_checks++;
      if (bus.div_valid_o !== 1'b0 || bus.div_doing_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL divzero_pulse[%0d]: got valid=%b doing=%b expected 0 0",
                 s, bus.div_valid_o, bus.div_doing_o);
      end
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [63:0] q;
    logic [63:0] r;
    bit          z;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] eq;
    logic [63:0] er;
    bit          ez;
    bit          s;
    int          kind;
    bus.div_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a    = {$urandom, $urandom} >> $urandom_range(0, 40);
      b    = {$urandom, $urandom} >> $urandom_range(0, 63);
      s    = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      if (kind == 0) b = 64'd0;
      if (kind == 1) b = '1;
      if (kind == 2) a = MIN_NEG;
      if (kind == 3) a = -a;
      if (kind == 4) b = -b;
      model_div(a, b, s, eq, er, ez);
      drive_req(a, b, s);
      await_result(lat, q, r, z);
      n_checks++;
      if (lat !== ((b == 64'd0) ? 1 : CALC_LAT)) begin
        n_fail++;
        $display("[TB] FAIL random_latency[%0d]: got %0d expected %0d",
                 i, lat, (b == 64'd0) ? 1 : CALC_LAT);
      end
      n_checks++;
      if (q !== eq || r !== er || z !== ez) begin
        n_fail++;
        $display("[TB] FAIL random_result[%0d] a=%h b=%h s=%b: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                 i, a, b, s, q, r, z, eq, er, ez);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [63:0] q;
    logic [63:0] r;
    bit          z;
    logic [63:0] eq;
    logic [63:0] er;
    bit          ez;
    bus.div_ready = 1'b1;
    drive_req(64'd1000, 64'd33, 1'b0);
    await_result(lat, q, r, z);
    // Request held from the handshake cycle: it must wait for IDLE.
    bus.dividend_i      = 64'd77777;
    bus.divisor_i       = 64'd123;
    bus.div_signed_i    = 1'b0;
    bus.div_datavaild_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.div_doing_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle_gap: got doing=%b expected 0", bus.div_doing_o);
    end
    @(negedge clk);
    n_checks++;
    if (bus.div_doing_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_accept: got doing=%b expected 1", bus.div_doing_o);
    end
    bus.div_datavaild_i = 1'b0;
    model_div(64'd77777, 64'd123, 1'b0, eq, er, ez);
    await_result(lat, q, r, z);
    n_checks++;
    if (lat !== CALC_LAT || q !== eq || r !== er || z !== ez) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got lat=%0d q=%0d r=%0d z=%b expected lat=%0d q=%0d r=%0d z=%b",
               lat, q, r, z, CALC_LAT, eq, er, ez);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [63:0] eq;
    logic [63:0] er;
    bit          ez;
    bit          stable;
    bus.div_ready = 1'b0;
    model_div(64'd1234567, 64'd89, 1'b0, eq, er, ez);
    drive_req(64'd1234567, 64'd89, 1'b0);
    lat = 0;
    while (bus.div_valid_o !== 1'b1 && lat < MAX_WAIT) begin
      if (lat == 10) begin
        bus.dividend_i      = 64'd999;
        bus.divisor_i       = 64'd3;
        bus.div_datavaild_i = 1'b1;
      end
      if (lat == 11) bus.div_datavaild_i = 1'b0;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== CALC_LAT || bus.quotient_o !== eq || bus.remainder_o !== er) begin
      n_fail++;
      $display("[TB] FAIL bp_result: got lat=%0d q=%0d r=%0d expected lat=%0d q=%0d r=%0d",
               lat, bus.quotient_o, bus.remainder_o, CALC_LAT, eq, er);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.div_datavaild_i = (i == 3);
      bus.dividend_i      = 64'd50;
      bus.divisor_i       = 64'd0;
      @(negedge clk);
      if (bus.div_valid_o !== 1'b1 || bus.quotient_o !== eq ||
          bus.remainder_o !== er || bus.div_by_zero_o !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_stable: got valid=%b q=%0d r=%0d z=%b expected valid=1 q=%0d r=%0d z=0",
               bus.div_valid_o, bus.quotient_o, bus.remainder_o, bus.div_by_zero_o, eq, er);
    end
    bus.div_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.div_doing_o !== 1'b0 || bus.div_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_release: got doing=%b valid=%b expected 0 0",
               bus.div_doing_o, bus.div_valid_o);
    end
    @(negedge clk);
    n_checks++;
    if (bus.div_doing_o !== 1'b0 || bus.quotient_o !== eq) begin
      n_fail++;
      $display("[TB] FAIL bp_no_stale: got doing=%b q=%0d expected doing=0 q=%0d",
               bus.div_doing_o, bus.quotient_o, eq);
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [63:0] q;
    logic [63:0] r;
    bit          z;
    bus.div_ready = 1'b1;
    drive_req(64'hFFFF_FFFF_0000_1234, 64'd3, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.div_doing_o !== 1'b0 || bus.div_valid_o !== 1'b0 ||
        bus.quotient_o !== 64'd0 || bus.remainder_o !== 64'd0 || bus.div_by_zero_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_clear: got doing=%b valid=%b q=%h r=%h z=%b expected all zero",
               bus.div_doing_o, bus.div_valid_o, bus.quotient_o, bus.remainder_o, bus.div_by_zero_o);
    end
    rst = 1'b0;
    drive_req(64'd9, 64'd3, 1'b0);
    await_result(lat, q, r, z);
    n_checks++;
    if (lat !== CALC_LAT || q !== 64'd3 || r !== 64'd0 || z !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_fresh: got lat=%0d q=%0d r=%0d z=%b expected lat=%0d q=3 r=0 z=0",
               lat, q, r, z, CALC_LAT);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    rst                 = 1'b1;
    bus.div_datavaild_i = 1'b0;
    bus.div_signed_i    = 1'b0;
    bus.dividend_i      = '0;
    bus.divisor_i       = '0;
    bus.div_ready       = 1'b0;
    $display("[TB] radix2_div bench start, signed path %0s", SIGNED_EN ? "enabled" : "disabled");
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
